// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 2R/1W register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward an in-flight write to the read ports in the same cycle.
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              busy1,
    output logic              busy2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              reserveEn,
    input  logic [ADDR_W-1:0] reserveReg,
    input  logic              flush,
    output logic              reserveConflict
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam bit ZR = ZERO_REG == 1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busyNext;
    logic              wrOk;
    logic              rsvOk;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic              storedBusy1;
    logic              storedBusy2;

    // Writes and reserves aimed at a hardwired r0 are dropped here, so r0 is never touched.
    assign wrOk  = RegWrite && !(ZR && writeReg == '0);
    assign rsvOk = reserveEn && !(ZR && reserveReg == '0);
    assign reserveConflict = rsvOk && busy[reserveReg];

    // Next busy vector: a new reservation wins over both the write-back clear and flush.
    always_comb begin
        for (int i = 0; i < NREGS; i++)
            busyNext[i] = (rsvOk && reserveReg == ADDR_W'(i)) ||
                          (busy[i] && !flush && !(wrOk && writeReg == ADDR_W'(i)));
    end

    // Register storage and scoreboard; reset overrides every other request.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wrOk)
                regs[writeReg] <= writeData;
            busy <= busyNext;
        end
    end

    // Committed state seen by the read ports; a hardwired r0 always reads zero and idle.
    always_comb begin
        stored1     = (ZR && readReg1 == '0) ? '0 : regs[readReg1];
        stored2     = (ZR && readReg2 == '0) ? '0 : regs[readReg2];
        storedBusy1 = !(ZR && readReg1 == '0) && busy[readReg1];
        storedBusy2 = !(ZR && readReg2 == '0) && busy[readReg2];
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the write being committed this edge; a same-cycle reserve keeps it busy.
    always_comb begin
        readData1 = (wrOk && writeReg == readReg1) ? writeData : stored1;
        readData2 = (wrOk && writeReg == readReg2) ? writeData : stored2;
        busy1     = (wrOk && writeReg == readReg1) ? (rsvOk && reserveReg == readReg1) : storedBusy1;
        busy2     = (wrOk && writeReg == readReg2) ? (rsvOk && reserveReg == readReg2) : storedBusy2;
    end
`else
    // Without forwarding the read ports show only pre-edge state.
    always_comb begin
        readData1 = stored1;
        readData2 = stored2;
        busy1     = storedBusy1;
        busy2     = storedBusy2;
    end
`endif
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed plus random checks of reg_file_scoreboard against an array model.
module tb_reg_file_scoreboard;
    logic        clock = 0;
    logic        reset = 0;
    logic [4:0]  readReg1 = 0, readReg2 = 0, writeReg = 0, reserveReg = 0;
    logic [31:0] readData1, readData2, writeData = 0;
    logic        busy1, busy2, RegWrite = 0, reserveEn = 0, flush = 0, reserveConflict;

    int checks = 0;
    int errors = 0;
    bit modelValid = 0;
    logic [31:0] mData [32];
    bit          mBusy [32];

    reg_file_scoreboard dut (
        .clock(clock), .reset(reset),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .busy1(busy1), .busy2(busy2),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .reserveEn(reserveEn), .reserveReg(reserveReg), .flush(flush),
        .reserveConflict(reserveConflict)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] expData(input logic [4:0] r);
        logic [31:0] v;
        v = (r == 0) ? 32'd0 : mData[r];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && writeReg == r && r != 0) v = writeData;
`endif
        return v;
    endfunction

    function automatic logic expBusy(input logic [4:0] r);
        logic b;
        b = (r != 0) && mBusy[r];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && writeReg == r && r != 0) b = reserveEn && reserveReg == r;
`endif
        return b;
    endfunction

    // Mid-cycle: compare all combinational outputs against the model.
    task automatic settle();
        @(negedge clock);
        if (modelValid) begin
            chk("readData1", readData1, expData(readReg1));
            chk("readData2", readData2, expData(readReg2));
            chk("busy1", 32'(busy1), 32'(expBusy(readReg1)));
            chk("busy2", 32'(busy2), 32'(expBusy(readReg2)));
            chk("reserveConflict", 32'(reserveConflict),
                32'(reserveEn && reserveReg != 0 && mBusy[reserveReg]));
        end
    endtask

    // Clock edge: apply the architectural rules to the model, then release inputs.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            foreach (mData[i]) begin mData[i] = 0; mBusy[i] = 0; end
            modelValid = 1;
        end else begin
            if (flush) foreach (mBusy[i]) mBusy[i] = 0;
            if (RegWrite && writeReg != 0) begin
                mData[writeReg] = writeData;
                mBusy[writeReg] = 0;
            end
            if (reserveEn && reserveReg != 0) mBusy[reserveReg] = 1;
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; RegWrite = 0; reserveEn = 0; flush = 0;
    endtask

    initial begin
        // reset with reads of r7 / r31
        reset = 1; readReg1 = 7; readReg2 = 31;
        settle(); tick();
        idle(); settle();
        chk("rst_rd1", readData1, 0); chk("rst_rd2", readData2, 0);
        chk("rst_b1", 32'(busy1), 0); chk("rst_b2", 32'(busy2), 0);
        chk("rst_conf", 32'(reserveConflict), 0);
        tick();
        // write r5 then read back
        RegWrite = 1; writeReg = 5; writeData = 32'hDEADBEEF; readReg1 = 5;
        settle(); tick();
        idle(); settle(); chk("r5", readData1, 32'hDEADBEEF); tick();
        // write to r0 discarded
        RegWrite = 1; writeReg = 0; writeData = 32'h1234; readReg2 = 0;
        settle(); chk("r0_same", readData2, 0); tick();
        idle(); settle(); chk("r0_after", readData2, 0); tick();
        // reserve r3, re-reserve conflicts, write-back clears
        reserveEn = 1; reserveReg = 3; readReg1 = 3;
        settle(); chk("r3_conf0", 32'(reserveConflict), 0); tick();
        settle(); chk("r3_busy", 32'(busy1), 1); chk("r3_conf1", 32'(reserveConflict), 1); tick();
        idle(); RegWrite = 1; writeReg = 3; writeData = 32'h55;
        settle(); tick();
        idle(); settle(); chk("r3_free", 32'(busy1), 0); chk("r3_data", readData1, 32'h55); tick();
        // same-cycle reserve and write of r4
        reserveEn = 1; reserveReg = 4; RegWrite = 1; writeReg = 4; writeData = 32'hAA;
        settle(); tick();
        idle(); readReg1 = 4; settle();
        chk("r4_data", readData1, 32'hAA); chk("r4_busy", 32'(busy1), 1); tick();
        // flush with reserve r9
        flush = 1; reserveEn = 1; reserveReg = 9;
        settle(); tick();
        idle(); readReg1 = 9; readReg2 = 4; settle();
        chk("flush_r9", 32'(busy1), 1); chk("flush_r4", 32'(busy2), 0); tick();
        // same-cycle read of a write to r8
        RegWrite = 1; writeReg = 8; writeData = 32'h77; readReg1 = 8;
        settle();
`ifdef REGFILE_BYPASS_EN
        chk("r8_bypass", readData1, 32'h77);
`else
        chk("r8_old", readData1, 0);
`endif
        tick();
        idle(); settle(); chk("r8_next", readData1, 32'h77); tick();
        // r2 busy with 0x99, then reset with a competing write
        reserveEn = 1; reserveReg = 2; RegWrite = 1; writeReg = 2; writeData = 32'h99;
        settle(); tick();
        idle(); readReg2 = 2; settle();
        chk("r2_data", readData2, 32'h99); chk("r2_busy", 32'(busy2), 1); tick();
        reset = 1; RegWrite = 1; writeReg = 2; writeData = 32'h12; reserveEn = 1; reserveReg = 2;
        settle(); tick();
        idle(); settle(); chk("r2_rst_data", readData2, 0); chk("r2_rst_busy", 32'(busy2), 0); tick();
        // random traffic, indices biased low so collisions are frequent
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            RegWrite   = $urandom_range(0, 1) == 1;
            reserveEn  = $urandom_range(0, 9) < 4;
            flush      = $urandom_range(0, 15) == 0;
            writeReg   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            reserveReg = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            readReg1   = 5'($urandom_range(0, 1) == 0 ? writeReg : $urandom_range(0, 7));
            readReg2   = 5'($urandom_range(0, 1) == 0 ? reserveReg : $urandom_range(0, 31));
            writeData  = $urandom;
            settle(); tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
